// File: rtl/time_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : time_display_scanner
// Description : Six-digit multiplexed 7-segment scanner for hh:mm:ss.
//               Frame-coherent input snapshot, BCD split, dash on
//               out-of-range fields, optional hours leading blank,
//               per-slot anti-ghost blanking and a tick-driven colon.
// Revision    : 1.0 - initial release
// ============================================================================
module time_display_scanner #(
    parameter int DIV        = 50000,
    parameter int ACTIVE_LOW = 1,
    parameter int LEAD_BLANK = 0
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic       iTick,
    input  logic [5:0] iSec,
    input  logic [5:0] iMin,
    input  logic [4:0] iHour,
    output logic [6:0] oSeg,
    output logic       oDp,
    output logic [5:0] oDig
);

    localparam int              c_DW      = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [c_DW-1:0] c_LAST    = c_DW'(DIV - 1);
    // Inactive levels double as XOR masks that apply the output polarity.
    localparam logic [6:0]      c_SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [5:0]      c_DIG_OFF = (ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
    localparam logic            c_DP_OFF  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [6:0]      c_DASH    = 7'h40;
    localparam logic [6:0]      c_BLANK   = 7'h00;

    logic [c_DW-1:0] r_div;
    logic [2:0]      r_idx;
    logic [5:0]      r_sec;
    logic [5:0]      r_min;
    logic [4:0]      r_hour;
    logic            r_phase;
    logic [6:0]      r_seg;
    logic            r_dp;
    logic [5:0]      r_dig;

    logic            w_slot_end;
    logic            w_frame_end;
    logic [3:0]      w_sec_t;
    logic [3:0]      w_sec_o;
    logic [3:0]      w_min_t;
    logic [3:0]      w_min_o;
    logic [3:0]      w_hour_t;
    logic [3:0]      w_hour_o;
    logic            w_sec_bad;
    logic            w_min_bad;
    logic            w_hour_bad;
    logic [6:0]      w_glyph;
    logic [5:0]      w_dig_on;
    logic            w_dp_on;

    // Lit-segment pattern (gfedcba, 1 = lit) for a decimal digit.
    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'd0:    f_glyph = 7'h3F;
            4'd1:    f_glyph = 7'h06;
            4'd2:    f_glyph = 7'h5B;
            4'd3:    f_glyph = 7'h4F;
            4'd4:    f_glyph = 7'h66;
            4'd5:    f_glyph = 7'h6D;
            4'd6:    f_glyph = 7'h7D;
            4'd7:    f_glyph = 7'h07;
            4'd8:    f_glyph = 7'h7F;
            4'd9:    f_glyph = 7'h6F;
            default: f_glyph = 7'h00;
        endcase
    endfunction

    assign w_slot_end  = (r_div == c_LAST);
    assign w_frame_end = w_slot_end && (r_idx == 3'd5);

    // Slot divider and digit index; index advances on the last cycle of a slot.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_div <= '0;
            r_idx <= 3'd0;
        end else if (w_slot_end) begin
            r_div <= '0;
            r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_div <= r_div + c_DW'(1);
        end
    end

    // Latch all three fields together at frame end so a frame never tears.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_sec  <= 6'd0;
            r_min  <= 6'd0;
            r_hour <= 5'd0;
        end else if (w_frame_end) begin
            r_sec  <= iSec;
            r_min  <= iMin;
            r_hour <= iHour;
        end
    end

    // Colon phase flips on every seconds tick, independent of the snapshot.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_phase <= 1'b1;
        end else if (iTick) begin
            r_phase <= ~r_phase;
        end
    end

    // BCD split and range checks on the snapshot values.
    always_comb begin
        w_sec_t    = 4'(r_sec / 6'd10);
        w_sec_o    = 4'(r_sec % 6'd10);
        w_min_t    = 4'(r_min / 6'd10);
        w_min_o    = 4'(r_min % 6'd10);
        w_hour_t   = 4'(r_hour / 5'd10);
        w_hour_o   = 4'(r_hour % 5'd10);
        w_sec_bad  = (r_sec >= 6'd60);
        w_min_bad  = (r_min >= 6'd60);
        w_hour_bad = (r_hour >= 5'd24);
    end

    // Select the glyph for the current slot.
    always_comb begin
        w_glyph = c_BLANK;
        case (r_idx)
            3'd0: w_glyph = w_sec_bad  ? c_DASH : f_glyph(w_sec_o);
            3'd1: w_glyph = w_sec_bad  ? c_DASH : f_glyph(w_sec_t);
            3'd2: w_glyph = w_min_bad  ? c_DASH : f_glyph(w_min_o);
            3'd3: w_glyph = w_min_bad  ? c_DASH : f_glyph(w_min_t);
            3'd4: w_glyph = w_hour_bad ? c_DASH : f_glyph(w_hour_o);
            3'd5: begin
                if (w_hour_bad) begin
                    w_glyph = c_DASH;
                end else if ((LEAD_BLANK != 0) && (w_hour_t == 4'd0)) begin
                    w_glyph = c_BLANK;
                end else begin
                    w_glyph = f_glyph(w_hour_t);
                end
            end
            default: w_glyph = c_BLANK;
        endcase
    end

    // Digit enable with a dead first cycle per slot, and colon dots.
    always_comb begin
        w_dig_on = (r_div == '0) ? 6'd0 : (6'd1 << r_idx);
        w_dp_on  = r_phase && ((r_idx == 3'd2) || (r_idx == 3'd4));
    end

    // Registered outputs with polarity applied; disable forces inactive.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_seg <= c_SEG_OFF;
            r_dp  <= c_DP_OFF;
            r_dig <= c_DIG_OFF;
        end else if (iEn) begin
            r_seg <= w_glyph ^ c_SEG_OFF;
            r_dp  <= w_dp_on ^ c_DP_OFF;
            r_dig <= w_dig_on ^ c_DIG_OFF;
        end else begin
            r_seg <= c_SEG_OFF;
            r_dp  <= c_DP_OFF;
            r_dig <= c_DIG_OFF;
        end
    end

    assign oSeg = r_seg;
    assign oDp  = r_dp;
    assign oDig = r_dig;

endmodule
`default_nettype wire

// File: tb/tb_time_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_display_scanner
// Description : Self-checking bench for time_display_scanner. Two instances
//               (active-low / no lead blank, active-high / lead blank) are
//               compared cycle by cycle against a frame-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_display_scanner;

    localparam int DIV = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       tick  = 1'b0;
    logic [5:0] sec   = 6'd0;
    logic [5:0] min   = 6'd0;
    logic [4:0] hour  = 5'd0;

    logic [6:0] seg_a;
    logic       dp_a;
    logic [5:0] dig_a;
    logic [6:0] seg_b;
    logic       dp_b;
    logic [5:0] dig_b;

    int n_chk = 0;
    int n_err = 0;

    // Model state: cycles since reset release, frame snapshot, colon phase.
    int         k      = 0;
    logic [5:0] m_sec  = 6'd0;
    logic [5:0] m_min  = 6'd0;
    logic [4:0] m_hour = 5'd0;
    bit         m_phase = 1'b1;

    time_display_scanner #(.DIV(DIV), .ACTIVE_LOW(1), .LEAD_BLANK(0)) u_dut_a (
        .iClk (clk), .iRst (rst_n), .iEn (en), .iTick (tick),
        .iSec (sec), .iMin (min), .iHour (hour),
        .oSeg (seg_a), .oDp (dp_a), .oDig (dig_a)
    );

    time_display_scanner #(.DIV(DIV), .ACTIVE_LOW(0), .LEAD_BLANK(1)) u_dut_b (
        .iClk (clk), .iRst (rst_n), .iEn (en), .iTick (tick),
        .iSec (sec), .iMin (min), .iHour (hour),
        .oSeg (seg_b), .oDp (dp_b), .oDig (dig_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic logic [6:0] digit_glyph(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Lit pattern for slot idx from the model snapshot, before polarity.
    function automatic logic [6:0] slot_glyph(input int idx, input bit lb);
        int v;
        int lim;
        int d;
        case (idx / 2)
            0:       begin v = int'(m_sec);  lim = 60; end
            1:       begin v = int'(m_min);  lim = 60; end
            default: begin v = int'(m_hour); lim = 24; end
        endcase
        if (v >= lim) return 7'h40;
        d = (idx % 2 == 1) ? v / 10 : v % 10;
        if (idx == 5 && lb && d == 0) return 7'h00;
        return digit_glyph(d);
    endfunction

    // One clock: predict registered outputs, advance model, compare after edge.
    task automatic step();
        int         dv;
        int         ix;
        logic [6:0] g_lb0;
        logic [6:0] g_lb1;
        logic [5:0] dg;
        logic       dp;
        logic [6:0] es_a, es_b;
        logic [5:0] ed_a, ed_b;
        logic       ep_a, ep_b;
        dv    = k % DIV;
        ix    = (k / DIV) % 6;
        g_lb0 = slot_glyph(ix, 1'b0);
        g_lb1 = slot_glyph(ix, 1'b1);
        dg    = (dv == 0) ? 6'd0 : 6'(1 << ix);
        dp    = m_phase && (ix == 2 || ix == 4);
        if (en) begin
            es_a = ~g_lb0; ed_a = ~dg; ep_a = ~dp;
            es_b = g_lb1;  ed_b = dg;  ep_b = dp;
        end else begin
            es_a = 7'h7F; ed_a = 6'h3F; ep_a = 1'b1;
            es_b = 7'h00; ed_b = 6'h00; ep_b = 1'b0;
        end
        if (ix == 5 && dv == DIV - 1) begin
            m_sec  = sec;
            m_min  = min;
            m_hour = hour;
        end
        if (tick) m_phase = ~m_phase;
        k++;
        @(posedge clk);
        @(negedge clk);
        chk("seg_a", 32'(seg_a), 32'(es_a));
        chk("dig_a", 32'(dig_a), 32'(ed_a));
        chk("dp_a",  32'(dp_a),  32'(ep_a));
        chk("seg_b", 32'(seg_b), 32'(es_b));
        chk("dig_b", 32'(dig_b), 32'(ed_b));
        chk("dp_b",  32'(dp_b),  32'(ep_b));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_inactive(input string tag);
        chk({tag, "_seg_a"}, 32'(seg_a), 32'h7F);
        chk({tag, "_dig_a"}, 32'(dig_a), 32'h3F);
        chk({tag, "_dp_a"},  32'(dp_a),  32'h1);
        chk({tag, "_seg_b"}, 32'(seg_b), 32'h00);
        chk({tag, "_dig_b"}, 32'(dig_b), 32'h00);
        chk({tag, "_dp_b"},  32'(dp_b),  32'h0);
    endtask

    // Assert reset between edges, check the asynchronous effect, then release.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_inactive({tag, "_async"});
        @(posedge clk);
        @(negedge clk);
        check_inactive({tag, "_held"});
        rst_n   = 1'b1;
        k       = 0;
        m_sec   = 6'd0;
        m_min   = 6'd0;
        m_hour  = 5'd0;
        m_phase = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset("rst0");
        en = 1'b1;

        // First frame shows zeros even though inputs change mid-frame.
        run(10);
        hour = 5'd12; min = 6'd34; sec = 6'd56;
        run(40);

        // Colon toggles with ticks.
        tick = 1'b1; step(); tick = 1'b0;
        run(26);
        tick = 1'b1; step(); tick = 1'b0;
        run(24);

        // Out-of-range seconds, hours leading blank.
        sec = 6'd60; min = 6'd59; hour = 5'd7;
        run(50);
        hour = 5'd25; min = 6'd63; sec = 6'd9;
        run(50);
        hour = 5'd23; min = 6'd0; sec = 6'd59;

        // Tick coinciding with a snapshot.
        while ((k % (6 * DIV)) != (6 * DIV - 1)) step();
        tick = 1'b1; step(); tick = 1'b0;
        run(30);

        // Display disable mid-slot.
        run(2);
        en = 1'b0; run(10);
        en = 1'b1; run(30);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                sec  = 6'($urandom_range(0, 63));
                min  = 6'($urandom_range(0, 63));
                hour = 5'($urandom_range(0, 31));
            end
            tick = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 19) != 0);
            step();
        end
        tick = 1'b0;
        en   = 1'b1;
        sec = 6'd45; min = 6'd12; hour = 5'd9;
        run(30);

        // Reset at divider 2, idx 3; restart from slot 0 with zero snapshot.
        tick = 1'b1; step(); tick = 1'b0;
        while ((k % (6 * DIV)) != (3 * DIV + 2)) step();
        do_reset("rst1");
        run(60);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_display_scanner.md
Name: time_display_scanner

Overview:
- Downstream consumer of the seconds/minutes/hours modulo counters in the simple clock design.
- Takes their binary values, splits each into BCD tens/ones digits, and time-multiplexes six digits onto a common 7-segment display.
- Provides anti-ghosting blanking, a coherent per-frame snapshot of the inputs, and a 1 Hz blinking colon driven by the seconds tick.

Parameters:
- DIV, 50000: clock cycles per digit slot (≥2); one full frame = 6*DIV cycles.
- ACTIVE_LOW, 1: 1 = oSeg, oDp, oDig active-low; 0 = all active-high.
- LEAD_BLANK, 0: 1 = blank hours-tens digit when hours < 10.

Ports:
- iClk  in  1  system clock, all logic on rising edge.
- iRst  in  1  asynchronous active-low reset.
- iEn  in  1  display enable; low forces all outputs to inactive level, scanning continues.
- iTick  in  1  one-cycle pulse at 1 Hz (seconds enable); toggles colon phase.
- iSec  in  6  seconds value, legal 0..59.
- iMin  in  6  minutes value, legal 0..59.
- iHour  in  5  hours value, legal 0..23.
- oSeg  out  7  segments {g,f,e,d,c,b,a}.
- oDp  out  1  decimal point (colon dot).
- oDig  out  6  digit select, one-hot when active; bit0 = seconds-ones (rightmost), bit5 = hours-tens.

Behaviour:
- Reset (iRst low, async):
  - divider = 0, idx = 0, snapshot regs = 0, colon phase = 1.
  - oDig/oSeg/oDp at inactive level (ACTIVE_LOW=1: 6'h3F, 7'h7F, 1).
- Divider: counts 0..DIV-1, wraps to 0. idx increments 0..5 when divider == DIV-1; wraps 5 -> 0.
- Digit mapping, idx 0..5: sec ones, sec tens, min ones, min tens, hour ones, hour tens.
- Snapshot: iSec/iMin/iHour are latched together on the cycle where idx == 5 and divider == DIV-1. They are displayed from the next frame on. Mid-frame input changes never tear a frame. The first frame after reset shows 00:00:00.
- BCD: tens = v/10, ones = v%10, on snapshot values.
  - Out-of-range value (sec/min ≥ 60, hour ≥ 24): both digits of that field show dash (g only).
  - LEAD_BLANK: hour-tens digit 0 shows blank.
- Glyphs, gfedcba with 1 = lit, before polarity: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F, dash=40, blank=00.
  - ACTIVE_LOW inverts glyphs, dp and digit select.
- Blanking: in the first cycle of every slot (divider == 0), oDig is all inactive. For divider 1..DIV-1, only oDig[idx] is active.
- Colon: oDp is active in slots idx 2 and 4 when colon phase == 1, otherwise inactive.
  - iTick toggles colon phase. iTick in the same cycle as a snapshot: both take effect, independently.
- Output timing:
  - All outputs are registered. Outputs at cycle n+1 reflect the divider, idx, snapshot and phase state at cycle n.
  - iEn is sampled with the same one-cycle latency.
- Reset mid-frame: all outputs go to their inactive level immediately (asynchronously). After release, scanning restarts at idx 0, divider 0.
- No combinational path from any input to any output.

Test Plan:
- Reset release, DIV=4, inputs 0 -> oDig (active-low) cycles through 3F, 3E, 3E, 3E, 3F, 3D, ... Each blank cycle is followed by 3 active cycles. oSeg = 40 (glyph 0) during active cycles. The frame repeats every 24 cycles.
- iHour=12, iMin=34, iSec=56 applied mid-frame 0 -> frame 0 still shows 000000. Frame 1 shows slots 0..5 = 02,12,19,30,24,79 (6,5,4,3,2,1 active-low).
- iTick pulse at cycle 30 -> oDp goes from 0 to 1 in slots 2 and 4 from cycle 31 on. A second iTick restores oDp = 0 in those slots. oDp stays 1 in all other slots throughout.
- iSec=60, iMin=59 -> after the next snapshot, slots 0,1 show 3F (dash active-low) and slots 2,3 show 10, 12. LEAD_BLANK=1 with iHour=7: slot 5 shows 7F, slot 4 shows 78.
- iEn low for 10 cycles mid-slot -> outputs inactive starting the next cycle. idx/divider keep advancing; after iEn high, the display resumes in the correct slot with no phase slip.
- Assert iRst at divider=2, idx=3 -> outputs go inactive in the same cycle (async). After release, idx=0, colon phase=1, snapshot=0.
